// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b LSB-first through one full-adder cell.
// Reports unsigned borrow, signed overflow and zero with the result.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    count;
  logic             a_sgn;
  logic             b_sgn;

  logic             s;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] full;

  // One full-adder cell; b_sr is pre-inverted and carry starts at 1.
  always_comb begin
    s     = a_sr[0] ^ b_sr[0] ^ carry;
    c_nxt = (a_sr[0] & b_sr[0])
          | (a_sr[0] & carry)
          | (b_sr[0] & carry);
    last  = (count == CW'(WIDTH - 1));
    full  = {s, res};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      count  <= '0;
      a_sgn  <= 1'b0;
      b_sgn  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= ~b;
            a_sgn <= a[WIDTH-1];
            b_sgn <= b[WIDTH-1];
            carry <= 1'b1;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          carry <= c_nxt;
          res   <= (WIDTH-1)'(full >> 1);
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          count <= count + 1'b1;
          if (last) begin
            // Full result is {s, res}: final bit joins the earlier ones.
            diff   <= full;
            borrow <= ~c_nxt;
            ovf    <= (a_sgn != b_sgn) && (s != a_sgn);
            zero   <= (full == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and exhaustive checks for the bit-serial subtractor.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .borrow  (borrow),
    .ovf     (ovf),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one op (retrying until accepted) and wait for done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat);
    bit acc;
    acc = 0;
    lat = -1;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(posedge clk);
      #1;
      if (busy) acc = 1;
    end
    @(negedge clk);
    start = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL accept timeout a=%0h b=%0h", av, bv);
    end else begin
      for (int i = 1; i <= 12; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int busy_cyc;
    int done_bad;
    int sa, sb, r;
    logic [W-1:0] av, bv, ed;

    vecs[0] = '{4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0111, 4'b1100, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0};

    // Reset held with start high: reset must win.
    start = 1'b1;
    a = 4'b0111;
    b = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {borrow, ovf, zero}, 0);
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
      chk($sformatf("vec%0d_borrow", i), borrow, vecs[i].borrow);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
    end

    // Start held and operands changed while busy.
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 4'b0111;
    b = 4'b0011;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_accept", busy, 1);
    busy_cyc = 1;
    done_bad = 0;
    @(negedge clk);
    a = 4'b0000;
    b = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) done_bad++;
    end
    @(posedge clk);
    #1;
    chk("hold_busy_cycles", busy_cyc, 4);
    chk("hold_done_in_busy", done_bad, 0);
    chk("hold_busy_end", busy, 0);
    chk("hold_done", done, 1);
    chk("hold_diff", diff, 4'b0100);
    @(negedge clk);
    start = 1'b0;
    done_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) done_bad++;
    end
    chk("hold_single_done", done_bad, 0);

    // Leave nonzero results so the reset clear is visible.
    run_op(4'b0111, 4'b1000, lat);
    chk("pre_rst_diff", diff, 4'b1111);

    // Reset during the second SHIFT cycle.
    @(negedge clk);
    a = 4'b1000;
    b = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {borrow, ovf, zero}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    done_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_bad++;
    end
    chk("abort_no_done", done_bad, 0);
    run_op(4'b0110, 4'b0010, lat);
    chk("after_abort_lat", lat, 4);
    chk("after_abort_diff", diff, 4'b0100);

    // Exhaustive sweep against an integer model.
    for (int i = 0; i < 256; i++) begin
      av = W'(i >> 4);
      bv = W'(i);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      r = sa - sb;
      ed = W'((int'(av) - int'(bv)) & 15);
      run_op(av, bv, lat);
      chk($sformatf("ex_%0h_%0h_lat", av, bv), lat, 4);
      chk($sformatf("ex_%0h_%0h_diff", av, bv), diff, ed);
      chk($sformatf("ex_%0h_%0h_borrow", av, bv), borrow, av < bv);
      chk($sformatf("ex_%0h_%0h_ovf", av, bv), ovf, (r > 7) || (r < -8));
      chk($sformatf("ex_%0h_%0h_zero", av, bv), zero, ed == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
